peripheral_biu_master_bridge: RTL and testbench
===============================================

# peripheral_biu_master_bridge

Initiator-side companion to the SPRAM-to-BIU responder bridge. It accepts single or burst requests from a simple memory-style requester (DMA engine, bench driver, debug port). It drives them onto the BIU bus with the strobe/acknowledge protocol and counts data beats until the burst completes. Read data, beat addresses, completion and errors are returned to the requester.

## Interface
- XLEN, 64, data width.
- PLEN, 64, address width.

- rst  input  1  asynchronous reset, active-low.
- clk  input  1  clock; all logic on rising edge.
- mem_req_i  input  1  request valid; accepted when mem_ready_o=1.
- mem_ready_o  output  1  FSM idle, can accept a request.
- mem_we_i  input  1  1=write, 0=read.
- mem_addr_i  input  PLEN  start address.
- mem_size_i  input  3  BIU transfer size code.
- mem_type_i  input  3  BIU burst type (HBURST_* encoding).
- mem_prot_i  input  3  BIU protection.
- mem_lock_i  input  1  locked transfer.
- mem_wdata_i  input  XLEN  current write beat.
- mem_wdata_ack_o  output  1  current write beat consumed; present the next one.
- mem_rdata_o  output  XLEN  read beat data.
- mem_raddr_o  output  PLEN  address of the beat on mem_rdata_o.
- mem_rvalid_o  output  1  beat acknowledged, for both reads and writes.
- mem_done_o  output  1  one-cycle pulse at burst end.
- mem_err_o  output  1  one-cycle pulse with mem_done_o if the burst was aborted by an error.
- biu_stb_o  output  1  strobe.
- biu_stb_ack_i  input  1  strobe acknowledge.
- biu_d_ack_i  input  1  write-data acknowledge.
- biu_adri_o  output  PLEN  start address.
- biu_adro_i  input  PLEN  current beat address.
- biu_size_o, biu_type_o, biu_prot_o  output  3 each  registered copies of the request fields.
- biu_lock_o, biu_we_o  output  1 each  registered copies of the request fields.
- biu_d_o  output  XLEN  write data.
- biu_q_i  input  XLEN  read data.
- biu_ack_i  input  1  transfer acknowledge.
- biu_err_i  input  1  transfer error.

## Operation

**FSM states:** IDLE, STB, DATA.

**IDLE**
- mem_ready_o=1.
- On mem_req_i=1, latch all request fields into the biu_* output registers.
- Load beats_left = burst_len(mem_type_i). Lengths: SINGLE/INCR=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
- Next state: STB.

**STB**
- biu_stb_o=1 until biu_stb_ack_i is sampled high.
- Then drop biu_stb_o and go to DATA.

**DATA**
- Each cycle with biu_ack_i=1: pulse mem_rvalid_o, capture biu_q_i and biu_adro_i, decrement beats_left.
- When the final beat is acknowledged: pulse mem_done_o and go to IDLE.

**Beat acknowledges in STB state**
- A biu_ack_i arriving while still in STB is counted exactly as in DATA.
- If it is the final beat and biu_stb_ack_i is also high, go directly to IDLE with mem_done_o.

**Write data**
- biu_d_o = mem_wdata_i, combinational.
- mem_wdata_ack_o = biu_d_ack_i & biu_we_o & (state≠IDLE).

**Error handling**
- biu_err_i=1 in STB or DATA: drop biu_stb_o, pulse mem_done_o and mem_err_o, discard remaining beats, go to IDLE.
- The beat carrying the error does not raise mem_rvalid_o.

**biu_lock_o**
- Held for the whole transfer.
- Cleared on return to IDLE unless a new request with mem_lock_i=1 is accepted in that same cycle.

**beats_left:** 5 bits; it never underflows. An ack arriving in IDLE is ignored.

## Timing

**Reset values:** all outputs 0, except mem_ready_o=1. State IDLE, beats_left=0.
- Reset asserted mid-burst aborts immediately; no done or error pulse is produced.

**Cycle 0:** request accepted.
- **Cycle 1:** biu_stb_o=1, biu_adri_o valid, mem_ready_o=0.

**Strobe release:** biu_stb_o is low the cycle after biu_stb_ack_i is sampled high.

**Completion:**
- mem_rvalid_o, mem_rdata_o and mem_raddr_o are registered, appearing 1 cycle after biu_ack_i.
- mem_done_o is aligned with the last mem_rvalid_o.

**Against the SPRAM bridge, single read:**
- stb_ack in cycle 1.
- biu_ack in cycle 3.
- mem_rvalid_o and mem_done_o in cycle 4.
- mem_ready_o=1 in cycle 4; the next request can be accepted in cycle 4.

**Back-to-back requests:** not supported. Requests are serialised with at least one IDLE cycle between them.

## Structure
- peripheral_biu_pkg owns HBURST_*, HSIZE_*, PROT_*.
- New package function: burst_len(type) returning [4:0]. It is shared with the responder's type-to-count conversion.
- FSM state enum is local to this module.
- No sub-module; a single module of about 200 lines.

## Test plan
- **Single read:** addr 0x1000, SINGLE. Responder acks 2 cycles after stb_ack with q=0xDEADBEEF -> one mem_rvalid_o with rdata 0xDEADBEEF and raddr 0x1000; mem_done_o=1; mem_err_o=0.
- **INCR4 write at 0x2000:** 4 d_acks -> mem_wdata_ack_o pulses 4 times; biu_d_o follows mem_wdata_i; 4 mem_rvalid_o pulses; done on the 4th.
- **WRAP8 read at 0x3028:** raddr sequence 0x3028, 0x3030, 0x3038, 0x3000 … 0x3020 (8 beats) -> done only after the 8th.
- **Held strobe:** stb_ack delayed 5 cycles -> biu_stb_o and fields stable for 5 cycles, then drop the next cycle.
- **Error:** biu_err_i on beat 2 of INCR4 -> mem_err_o and mem_done_o pulse together; only 1 mem_rvalid_o pulse; later acks ignored; mem_ready_o=1.
- **Reset mid-burst:** rst low during DATA -> all outputs at reset values at once; no mem_done_o; next request runs normally.

Source files
------------

// File: rtl/peripheral_biu_master_bridge_pkg.sv
// Shared BIU bus encodings and the burst-type to beat-count helper.
// Both the initiator and responder bridges use burst_len.
package peripheral_biu_pkg;

  localparam int XLEN = 64;
  localparam int PLEN = 64;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic [2:0] PROT_INSTRUCTION = 3'b000;
  localparam logic [2:0] PROT_DATA        = 3'b001;
  localparam logic [2:0] PROT_PRIVILEGED  = 3'b010;
  localparam logic [2:0] PROT_BUFFERABLE  = 3'b100;

  function automatic logic [4:0] burst_len(input logic [2:0] btype);
    logic [4:0] len;
    case (btype)
      HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
      default:                      len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/peripheral_biu_master_bridge_if.sv
// Requester-side memory port plus BIU bus of the initiator bridge.
// master = the bridge, slave = requester/responder environment.
interface peripheral_biu_master_bridge_if;
  import peripheral_biu_pkg::*;

  logic            mem_req_i;
  logic            mem_ready_o;
  logic            mem_we_i;
  logic [PLEN-1:0] mem_addr_i;
  logic [2:0]      mem_size_i;
  logic [2:0]      mem_type_i;
  logic [2:0]      mem_prot_i;
  logic            mem_lock_i;
  logic [XLEN-1:0] mem_wdata_i;
  logic            mem_wdata_ack_o;
  logic [XLEN-1:0] mem_rdata_o;
  logic [PLEN-1:0] mem_raddr_o;
  logic            mem_rvalid_o;
  logic            mem_done_o;
  logic            mem_err_o;

  logic            biu_stb_o;
  logic            biu_stb_ack_i;
  logic            biu_d_ack_i;
  logic [PLEN-1:0] biu_adri_o;
  logic [PLEN-1:0] biu_adro_i;
  logic [2:0]      biu_size_o;
  logic [2:0]      biu_type_o;
  logic [2:0]      biu_prot_o;
  logic            biu_lock_o;
  logic            biu_we_o;
  logic [XLEN-1:0] biu_d_o;
  logic [XLEN-1:0] biu_q_i;
  logic            biu_ack_i;
  logic            biu_err_i;

  modport master (
    input  mem_req_i, mem_we_i, mem_addr_i, mem_size_i, mem_type_i, mem_prot_i,
           mem_lock_i, mem_wdata_i,
    output mem_ready_o, mem_wdata_ack_o, mem_rdata_o, mem_raddr_o, mem_rvalid_o,
           mem_done_o, mem_err_o,
    output biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_prot_o, biu_lock_o,
           biu_we_o, biu_d_o,
    input  biu_stb_ack_i, biu_d_ack_i, biu_adro_i, biu_q_i, biu_ack_i, biu_err_i
  );

  modport slave (
    output mem_req_i, mem_we_i, mem_addr_i, mem_size_i, mem_type_i, mem_prot_i,
           mem_lock_i, mem_wdata_i,
    input  mem_ready_o, mem_wdata_ack_o, mem_rdata_o, mem_raddr_o, mem_rvalid_o,
           mem_done_o, mem_err_o,
    input  biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_prot_o, biu_lock_o,
           biu_we_o, biu_d_o,
    output biu_stb_ack_i, biu_d_ack_i, biu_adro_i, biu_q_i, biu_ack_i, biu_err_i
  );

endinterface

// File: rtl/peripheral_biu_master_bridge.sv
// BIU initiator bridge: turns one memory-style request into a strobed BIU burst
// and returns each acknowledged beat, completion and error to the requester.
module peripheral_biu_master_bridge
  import peripheral_biu_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  peripheral_biu_master_bridge_if.master bus
);

  // state   | meaning
  // IDLE    | ready for a request, bus quiet
  // STB     | strobe held until stb_ack; early beat acks still counted
  // DATA    | counting beat acks until the burst completes
  typedef enum logic [1:0] {ST_IDLE, ST_STB, ST_DATA} state_e;

  state_e          state_q, state_d;
  logic [4:0]      beats_left_q, beats_left_d;
  logic [PLEN-1:0] adri_q, adri_d;
  logic [2:0]      size_q, size_d;
  logic [2:0]      type_q, type_d;
  logic [2:0]      prot_q, prot_d;
  logic            lock_q, lock_d;
  logic            we_q, we_d;
  logic            rvalid_q, rvalid_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [PLEN-1:0] raddr_q, raddr_d;

  logic busy, abort, beat_ack, last_beat;

  assign busy      = (state_q != ST_IDLE);
  assign abort     = busy && bus.biu_err_i;
  assign beat_ack  = busy && bus.biu_ack_i && !bus.biu_err_i && (beats_left_q != 5'd0);
  assign last_beat = beat_ack && (beats_left_q == 5'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      adri_q       <= '0;
      size_q       <= '0;
      type_q       <= '0;
      prot_q       <= '0;
      lock_q       <= 1'b0;
      we_q         <= 1'b0;
      rvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      raddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      adri_q       <= adri_d;
      size_q       <= size_d;
      type_q       <= type_d;
      prot_q       <= prot_d;
      lock_q       <= lock_d;
      we_q         <= we_d;
      rvalid_q     <= rvalid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      raddr_q      <= raddr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    adri_d       = adri_q;
    size_d       = size_q;
    type_d       = type_q;
    prot_d       = prot_q;
    lock_d       = lock_q;
    we_d         = we_q;
    rvalid_d     = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    raddr_d      = raddr_q;

    if (beat_ack) begin
      rvalid_d     = 1'b1;
      rdata_d      = bus.biu_q_i;
      raddr_d      = bus.biu_adro_i;
      beats_left_d = beats_left_q - 5'd1;
    end

    case (state_q)
      ST_IDLE: begin
        lock_d = 1'b0;
        if (bus.mem_req_i) begin
          adri_d       = bus.mem_addr_i;
          size_d       = bus.mem_size_i;
          type_d       = bus.mem_type_i;
          prot_d       = bus.mem_prot_i;
          lock_d       = bus.mem_lock_i;
          we_d         = bus.mem_we_i;
          beats_left_d = burst_len(bus.mem_type_i);
          state_d      = ST_STB;
        end
      end
      ST_STB: begin
        if (abort) begin
          done_d       = 1'b1;
          err_d        = 1'b1;
          beats_left_d = '0;
          lock_d       = 1'b0;
          state_d      = ST_IDLE;
        end else if (bus.biu_stb_ack_i) begin
          // All beats may already have been acked while the strobe was pending.
          if (last_beat || beats_left_q == 5'd0) begin
            done_d  = 1'b1;
            lock_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (abort) begin
          done_d       = 1'b1;
          err_d        = 1'b1;
          beats_left_d = '0;
          lock_d       = 1'b0;
          state_d      = ST_IDLE;
        end else if (last_beat) begin
          done_d  = 1'b1;
          lock_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_ready_o     = (state_q == ST_IDLE);
    bus.biu_stb_o       = (state_q == ST_STB);
    bus.mem_wdata_ack_o = bus.biu_d_ack_i & we_q & busy;
    bus.biu_d_o         = bus.mem_wdata_i;
    bus.biu_adri_o      = adri_q;
    bus.biu_size_o      = size_q;
    bus.biu_type_o      = type_q;
    bus.biu_prot_o      = prot_q;
    bus.biu_lock_o      = lock_q;
    bus.biu_we_o        = we_q;
    bus.mem_rvalid_o    = rvalid_q;
    bus.mem_rdata_o     = rdata_q;
    bus.mem_raddr_o     = raddr_q;
    bus.mem_done_o      = done_q;
    bus.mem_err_o       = err_q;
  end

endmodule

// File: tb/tb_peripheral_biu_master_bridge.sv
// Bench for the BIU initiator bridge: table of bursts driven through a
// responder model, with a beat scoreboard checked as read beats come back.
module tb_peripheral_biu_master_bridge;
  import peripheral_biu_pkg::*;

  logic clk;
  logic rst;

  peripheral_biu_master_bridge_if bus();

  peripheral_biu_master_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [2:0]  btype;
    logic        lock;
    int          stb_dly;
    int          gap;
    int          err_beat;   // -1: no error
    int          early;      // ack the single beat together with stb_ack
    int          n_drive;    // acks the responder issues (extra ones after an error)
    logic [63:0] qseed;
    int          exp_beats;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [63:0] a;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_rv, n_done, n_err, n_wack;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_addr(input logic [63:0] s, input logic [2:0] t, input int b);
    logic [63:0] span;
    int len;
    case (t)
      HBURST_WRAP4:  len = 4;
      HBURST_WRAP8:  len = 8;
      HBURST_WRAP16: len = 16;
      default:       len = 0;
    endcase
    if (len == 0) return s + 64'(b) * 64'd8;
    span = 64'(len) * 64'd8;
    return (s & ~(span - 64'd1)) | ((s + 64'(b) * 64'd8) & (span - 64'd1));
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_rvalid_o) begin
        n_rv++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rvalid: got raddr %0h want no beat", bus.mem_raddr_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rdata", bus.mem_rdata_o, e.d);
          chk("raddr", bus.mem_raddr_o, e.a);
        end
      end
      if (bus.mem_done_o) begin
        n_done++;
        if (bus.mem_err_o) chk1("err_beat_no_rvalid", bus.mem_rvalid_o, 1'b0);
        else begin
          chk1("done_with_last_rvalid", bus.mem_rvalid_o, 1'b1);
          chk("done_sb_empty", 64'(sb.size()), 64'd0);
        end
      end
      if (bus.mem_err_o) n_err++;
      if (bus.mem_wdata_ack_o) n_wack++;
    end
  end

  task automatic run_vec(input vec_t v);
    logic [63:0] q, a, wd;
    int last_idx;
    last_idx = v.exp_err ? v.err_beat : v.exp_beats - 1;
    n_rv = 0; n_done = 0; n_err = 0; n_wack = 0;
    @(posedge clk); #1;
    bus.mem_req_i  = 1'b1;
    bus.mem_we_i   = v.we;
    bus.mem_addr_i = v.addr;
    bus.mem_size_i = HSIZE_DWORD;
    bus.mem_type_i = v.btype;
    bus.mem_prot_i = PROT_DATA;
    bus.mem_lock_i = v.lock;
    @(posedge clk); #1;
    // scramble request inputs: bus fields must come from the latched copies
    bus.mem_req_i  = 1'b0;
    bus.mem_addr_i = ~v.addr;
    bus.mem_type_i = ~v.btype;
    bus.mem_we_i   = ~v.we;
    bus.mem_lock_i = 1'b0;
    chk1("ready_busy", bus.mem_ready_o, 1'b0);
    chk1("stb_cycle1", bus.biu_stb_o, 1'b1);
    chk1("lock_held", bus.biu_lock_o, v.lock);
    if (v.early != 0) begin
      q = v.qseed;
      bus.biu_stb_ack_i = 1'b1;
      bus.biu_ack_i     = 1'b1;
      bus.biu_q_i       = q;
      bus.biu_adro_i    = v.addr;
      sb.push_back('{q, v.addr});
      @(posedge clk); #1;
      bus.biu_stb_ack_i = 1'b0;
      bus.biu_ack_i     = 1'b0;
      chk1("early_stb_drop", bus.biu_stb_o, 1'b0);
      chk1("early_done", bus.mem_done_o, 1'b1);
      chk1("early_ready", bus.mem_ready_o, 1'b1);
    end else begin
      for (int d = 0; d < v.stb_dly; d++) begin
        chk1("stb_held", bus.biu_stb_o, 1'b1);
        chk("adri_held", bus.biu_adri_o, v.addr);
        chk("type_held", 64'(bus.biu_type_o), 64'(v.btype));
        chk("size_held", 64'(bus.biu_size_o), 64'(HSIZE_DWORD));
        chk1("we_held", bus.biu_we_o, v.we);
        @(posedge clk); #1;
      end
      chk1("stb_at_ack", bus.biu_stb_o, 1'b1);
      chk("adri", bus.biu_adri_o, v.addr);
      bus.biu_stb_ack_i = 1'b1;
      @(posedge clk); #1;
      bus.biu_stb_ack_i = 1'b0;
      chk1("stb_drop", bus.biu_stb_o, 1'b0);
      for (int b = 0; b < v.n_drive; b++) begin
        repeat (v.gap) begin @(posedge clk); #1; end
        a  = beat_addr(v.addr, v.btype, b);
        q  = v.qseed + 64'(b);
        wd = {32'hA5A5_0000 | 32'(b), v.addr[31:0]};
        bus.biu_ack_i   = 1'b1;
        bus.biu_err_i   = (b == v.err_beat);
        bus.biu_d_ack_i = v.we;
        bus.biu_q_i     = q;
        bus.biu_adro_i  = a;
        bus.mem_wdata_i = wd;
        if (b < v.exp_beats) sb.push_back('{q, a});
        #1;
        if (v.we) begin
          chk("biu_d_o", bus.biu_d_o, wd);
          chk1("wdata_ack", bus.mem_wdata_ack_o, (b <= last_idx));
        end
        @(posedge clk); #1;
        bus.biu_ack_i   = 1'b0;
        bus.biu_err_i   = 1'b0;
        bus.biu_d_ack_i = 1'b0;
        if (b == last_idx) begin
          chk1("done_pulse", bus.mem_done_o, 1'b1);
          chk1("err_pulse", bus.mem_err_o, v.exp_err);
          chk1("ready_after", bus.mem_ready_o, 1'b1);
          chk1("lock_cleared", bus.biu_lock_o, 1'b0);
        end else begin
          chk1("no_early_done", bus.mem_done_o, 1'b0);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("n_rvalid", 64'(n_rv), 64'(v.exp_beats));
    chk("n_done", 64'(n_done), 64'd1);
    chk("n_err", 64'(n_err), v.exp_err ? 64'd1 : 64'd0);
    chk("n_wdata_ack", 64'(n_wack), v.we ? 64'(last_idx + 1) : 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    tbl[0] = '{1'b0, 64'h1000, HBURST_SINGLE, 1'b0, 0, 1, -1, 0, 1,  64'hDEADBEEF,          1,  1'b0};
    tbl[1] = '{1'b1, 64'h2000, HBURST_INCR4,  1'b0, 0, 0, -1, 0, 4,  64'h1111_0000_0000_0000, 4, 1'b0};
    tbl[2] = '{1'b0, 64'h3028, HBURST_WRAP8,  1'b1, 0, 0, -1, 0, 8,  64'h2222_0000_0000_0000, 8, 1'b0};
    tbl[3] = '{1'b0, 64'h4000, HBURST_INCR,   1'b0, 5, 2, -1, 0, 1,  64'h3333_0000_0000_0000, 1, 1'b0};
    tbl[4] = '{1'b0, 64'h5000, HBURST_INCR4,  1'b0, 1, 0,  1, 0, 4,  64'h4444_0000_0000_0000, 1, 1'b1};
    tbl[5] = '{1'b0, 64'h6000, HBURST_SINGLE, 1'b0, 0, 0, -1, 1, 1,  64'h5555_0000_0000_0000, 1, 1'b0};
    tbl[6] = '{1'b1, 64'h7000, HBURST_INCR16, 1'b1, 2, 1, -1, 0, 16, 64'h6666_0000_0000_0000, 16, 1'b0};

    rst = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0;
    bus.mem_size_i = '0; bus.mem_type_i = '0; bus.mem_prot_i = '0;
    bus.mem_lock_i = 1'b0; bus.mem_wdata_i = '0;
    bus.biu_stb_ack_i = 1'b0; bus.biu_d_ack_i = 1'b0; bus.biu_adro_i = '0;
    bus.biu_q_i = '0; bus.biu_ack_i = 1'b0; bus.biu_err_i = 1'b0;
    n_rv = 0; n_done = 0; n_err = 0; n_wack = 0;

    #2;
    chk1("rst_ready", bus.mem_ready_o, 1'b1);
    chk1("rst_stb", bus.biu_stb_o, 1'b0);
    chk1("rst_rvalid", bus.mem_rvalid_o, 1'b0);
    chk1("rst_done", bus.mem_done_o, 1'b0);
    chk1("rst_lock", bus.biu_lock_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // reset asserted while the burst is in DATA
    @(posedge clk); #1;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 64'h9000;
    bus.mem_type_i = HBURST_INCR4; bus.mem_lock_i = 1'b1; bus.mem_size_i = HSIZE_DWORD;
    @(posedge clk); #1;
    bus.mem_req_i = 1'b0; bus.mem_lock_i = 1'b0;
    bus.biu_stb_ack_i = 1'b1;
    @(posedge clk); #1;
    bus.biu_stb_ack_i = 1'b0;
    chk1("pre_rst_lock", bus.biu_lock_o, 1'b1);
    n_done = 0;
    rst = 1'b0;
    #1;
    chk1("midrst_ready", bus.mem_ready_o, 1'b1);
    chk1("midrst_stb", bus.biu_stb_o, 1'b0);
    chk1("midrst_lock", bus.biu_lock_o, 1'b0);
    chk1("midrst_we", bus.biu_we_o, 1'b0);
    chk("midrst_adri", bus.biu_adri_o, 64'd0);
    chk1("midrst_done", bus.mem_done_o, 1'b0);
    chk1("midrst_err", bus.mem_err_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_vec(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
